// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int          DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST     = 32'h0000_0013;

    // Fetch sequencing states; the encoding is shared with the rest of the core.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_e;

    // A jump target is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read channel: req/ready request phase, rvalid data phase.
interface instruction_fetch_if #(
    parameter int XLEN = 32
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_obuf.sv
// Enabled output register with a configurable reset value.
module instruction_fetch_obuf #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Load on enable, otherwise hold; reset restores the configured value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, performs one memory read per fetch phase and
// registers the returned instruction together with its PC and PC+4.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [31:0]     NOP_INST     = DEFAULT_NOP_INST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                phase_fetch,
    input  logic                pc_update_en,
    input  logic                jump_taken,
    input  logic [XLEN-1:0]     jump_target,
    instruction_fetch_if.master imem,
    output logic [31:0]         inst,
    output logic [XLEN-1:0]     curr_pc_fd,
    output logic [XLEN-1:0]     next_pc_fd,
    output logic                stall_fetch,
    output logic                inst_addr_misaligned
);

    fetch_state_e    r_state;
    fetch_state_e    w_nextState;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_reqAddr;
    logic            r_misaligned;
    logic            w_capture;
    logic            w_latchReq;
    logic [XLEN-1:0] w_reqAddrPlus4;
    logic [XLEN-1:0] w_jumpAligned;

    assign w_reqAddrPlus4 = r_reqAddr + XLEN'(4);
    assign w_jumpAligned  = {jump_target[XLEN-1:2], 2'b00};

    // State register; reset abandons any in-flight read so a late rvalid is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, request latch strobe and capture strobe.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_latchReq  = 1'b0;
        case (r_state)
            IDLE: begin
                if (phase_fetch) begin
                    w_latchReq  = 1'b1;
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (imem.imem_ready) begin
                    if (imem.imem_rvalid) begin
                        w_capture   = 1'b1;
                        w_nextState = DONE;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    w_capture   = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (!phase_fetch) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request address is frozen at the start of a fetch so PC updates cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reqAddr <= RESET_VECTOR;
        end else if (w_latchReq) begin
            r_reqAddr <= r_pc;
        end
    end

    // Program counter: sequential step or word-aligned jump on the commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else if (pc_update_en) begin
            r_pc <= jump_taken ? w_jumpAligned : r_pc + XLEN'(4);
        end
    end

    // Sticky misaligned-target flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (pc_update_en && jump_taken && is_misaligned(jump_target[1:0])) begin
            r_misaligned <= 1'b1;
        end
    end

    assign imem.imem_req       = (r_state == REQ);
    assign imem.imem_addr      = r_reqAddr;
    assign stall_fetch         = (r_state == REQ) || (r_state == WAIT) ||
                                 ((r_state == IDLE) && phase_fetch);
    assign inst_addr_misaligned = r_misaligned;

    instruction_fetch_obuf #(
        .WIDTH       (32),
        .RESET_VALUE (NOP_INST)
    ) u_instBuf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_capture),
        .i_d   (imem.imem_rdata),
        .o_q   (inst)
    );

    instruction_fetch_obuf #(
        .WIDTH       (XLEN),
        .RESET_VALUE (RESET_VECTOR)
    ) u_currPcBuf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_capture),
        .i_d   (r_reqAddr),
        .o_q   (curr_pc_fd)
    );

    instruction_fetch_obuf #(
        .WIDTH       (XLEN),
        .RESET_VALUE (RESET_VECTOR + XLEN'(4))
    ) u_nextPcBuf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_capture),
        .i_d   (w_reqAddrPlus4),
        .o_q   (next_pc_fd)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: randomized fetches against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk                  = 1'b0;
    logic        rst_n                = 1'b1;
    logic        phase_fetch          = 1'b0;
    logic        pc_update_en         = 1'b0;
    logic        jump_taken           = 1'b0;
    logic [31:0] jump_target          = '0;
    logic [31:0] inst;
    logic [31:0] curr_pc_fd;
    logic [31:0] next_pc_fd;
    logic        stall_fetch;
    logic        inst_addr_misaligned;

    int errorCount = 0;
    int checkCount = 0;
    bit checkOn    = 1'b0;

    // Model state: architectural PC, registered outputs, per-cycle bus expectations.
    logic [31:0] mPc, mInst, mCurr, mNext;
    logic        mMis;
    logic        eReq, eStall;
    logic [31:0] eAddr;
    logic        pUpd, pJump;
    logic [31:0] pTgt;

    instruction_fetch_if #(.XLEN(32)) imemBus ();

    instruction_fetch #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .NOP_INST     (32'h0000_0013)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .phase_fetch          (phase_fetch),
        .pc_update_en         (pc_update_en),
        .jump_taken           (jump_taken),
        .jump_target          (jump_target),
        .imem                 (imemBus.master),
        .inst                 (inst),
        .curr_pc_fd           (curr_pc_fd),
        .next_pc_fd           (next_pc_fd),
        .stall_fetch          (stall_fetch),
        .inst_addr_misaligned (inst_addr_misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("imem_req", 32'(imemBus.imem_req), 32'(eReq));
            if (eReq) checkOutput("imem_addr", imemBus.imem_addr, eAddr);
            checkOutput("stall_fetch", 32'(stall_fetch), 32'(eStall));
            checkOutput("inst", inst, mInst);
            checkOutput("curr_pc_fd", curr_pc_fd, mCurr);
            checkOutput("next_pc_fd", next_pc_fd, mNext);
            checkOutput("inst_addr_misaligned", 32'(inst_addr_misaligned), 32'(mMis));
        end
    end

    task automatic resetModel();
        mPc   = 32'h0000_0000;
        mInst = 32'h0000_0013;
        mCurr = 32'h0000_0000;
        mNext = 32'h0000_0004;
        mMis  = 1'b0;
        pUpd  = 1'b0;
        pJump = 1'b0;
        pTgt  = '0;
        eReq  = 1'b0;
        eStall = 1'b0;
        eAddr = '0;
    endtask

    // Advance one cycle, commit the previous cycle's PC update to the model, drive inputs.
    task automatic applyStimulus(input logic ph, input logic upd, input logic jmp,
                                 input logic [31:0] tgt, input logic rdy,
                                 input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        if (pUpd) begin
            if (pJump) begin
                mPc = {pTgt[31:2], 2'b00};
                if (pTgt[1:0] != 2'b00) mMis = 1'b1;
            end else begin
                mPc = mPc + 32'd4;
            end
        end
        pUpd  = upd;
        pJump = jmp;
        pTgt  = tgt;
        phase_fetch          = ph;
        pc_update_en         = upd;
        jump_taken           = jmp;
        jump_target          = tgt;
        imemBus.imem_ready   = rdy;
        imemBus.imem_rvalid  = rv;
        imemBus.imem_rdata   = rd;
    endtask

    task automatic pcUpdate(input logic jmp, input logic [31:0] tgt);
        applyStimulus(1'b0, 1'b1, jmp, tgt, 1'b0, 1'b0, $urandom);
        eReq   = 1'b0;
        eStall = 1'b0;
    endtask

    // One complete fetch phase with a given memory timing; spurious rvalid where it must be ignored.
    task automatic doFetch(input int readyDelay, input int gap, input logic [31:0] data,
                           input bit midUpd, input logic midJump, input logic [31:0] midTgt,
                           input int holdExtra);
        logic [31:0] reqAddr;
        logic        lastCyc;
        logic        updNow;
        logic        rvNow;
        logic [31:0] rdNow;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        reqAddr = mPc;
        eReq    = 1'b0;
        eStall  = 1'b1;
        for (int k = 0; k <= readyDelay; k++) begin
            lastCyc = (k == readyDelay);
            updNow  = midUpd && (k == 0);
            rvNow   = lastCyc ? (gap == 0) : 1'($urandom_range(0, 1));
            rdNow   = (lastCyc && gap == 0) ? data : $urandom;
            applyStimulus(1'b1, updNow, midJump, midTgt, lastCyc, rvNow, rdNow);
            eReq   = 1'b1;
            eAddr  = reqAddr;
            eStall = 1'b1;
        end
        for (int k = 1; k < gap; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, $urandom);
            eReq   = 1'b0;
            eStall = 1'b1;
        end
        if (gap > 0) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, data);
            eReq   = 1'b0;
            eStall = 1'b1;
        end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        mInst  = data;
        mCurr  = reqAddr;
        mNext  = reqAddr + 32'd4;
        eReq   = 1'b0;
        eStall = 1'b0;
        for (int k = 0; k < holdExtra; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic randomFetch();
        logic [31:0] tgt;
        logic        jmp;
        tgt = $urandom;
        if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
        jmp = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1 && $urandom_range(0, 1) == 1) begin
            doFetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    1'b1, jmp, tgt, $urandom_range(0, 2));
        end else begin
            if ($urandom_range(0, 1) == 1) pcUpdate(jmp, tgt);
            doFetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    1'b0, 1'b0, '0, $urandom_range(0, 2));
        end
    endtask

    initial begin
        imemBus.imem_ready  = 1'b0;
        imemBus.imem_rvalid = 1'b0;
        imemBus.imem_rdata  = '0;
        resetModel();
        #1;
        rst_n   = 1'b0;
        checkOn = 1'b1;
        #1;
        checkOutput("reset_inst", inst, 32'h0000_0013);
        checkOutput("reset_curr_pc", curr_pc_fd, 32'h0000_0000);
        checkOutput("reset_next_pc", next_pc_fd, 32'h0000_0004);
        checkOutput("reset_req", 32'(imemBus.imem_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-wait fetch straight after reset.
        doFetch(0, 0, 32'h0010_0093, 1'b0, 1'b0, '0, 0);
        checkOutput("first_inst", inst, 32'h0010_0093);
        checkOutput("first_curr_pc", curr_pc_fd, 32'h0000_0000);
        checkOutput("first_next_pc", next_pc_fd, 32'h0000_0004);

        // Slow memory: ready after 3 cycles, data 2 cycles later.
        doFetch(3, 2, 32'h0020_8113, 1'b0, 1'b0, '0, 1);
        checkOutput("slow_inst", inst, 32'h0020_8113);

        // Aligned jump.
        pcUpdate(1'b1, 32'h0000_0100);
        doFetch(1, 1, 32'h0031_0193, 1'b0, 1'b0, '0, 0);
        checkOutput("jump_curr_pc", curr_pc_fd, 32'h0000_0100);
        checkOutput("jump_next_pc", next_pc_fd, 32'h0000_0104);
        checkOutput("jump_misaligned", 32'(inst_addr_misaligned), 32'd0);

        // Misaligned jump target is truncated and flagged.
        pcUpdate(1'b1, 32'h0000_0102);
        doFetch(0, 1, 32'h0041_8213, 1'b0, 1'b0, '0, 0);
        checkOutput("misjump_curr_pc", curr_pc_fd, 32'h0000_0100);
        checkOutput("misjump_flag", 32'(inst_addr_misaligned), 32'd1);

        // PC wrap at the top of the address space.
        pcUpdate(1'b1, 32'hFFFF_FFFC);
        doFetch(0, 0, 32'h0052_0293, 1'b0, 1'b0, '0, 0);
        checkOutput("wrap_curr_pc", curr_pc_fd, 32'hFFFF_FFFC);
        checkOutput("wrap_next_pc", next_pc_fd, 32'h0000_0000);
        pcUpdate(1'b0, '0);
        doFetch(2, 0, 32'h0062_8313, 1'b0, 1'b0, '0, 0);
        checkOutput("wrap_seq_curr_pc", curr_pc_fd, 32'h0000_0000);
        checkOutput("sticky_flag", 32'(inst_addr_misaligned), 32'd1);

        for (int n = 0; n < 30; n++) randomFetch();

        // Reset while waiting for data, then a late rvalid.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, $urandom);
        eReq   = 1'b0;
        eStall = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, $urandom);
        eReq   = 1'b1;
        eAddr  = mPc;
        eStall = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, $urandom);
        eReq   = 1'b0;
        eStall = 1'b1;
        #2;
        rst_n       = 1'b0;
        phase_fetch = 1'b0;
        resetModel();
        #1;
        checkOutput("wait_reset_req", 32'(imemBus.imem_req), 32'd0);
        checkOutput("wait_reset_inst", inst, 32'h0000_0013);
        checkOutput("wait_reset_curr_pc", curr_pc_fd, 32'h0000_0000);
        checkOutput("wait_reset_flag", 32'(inst_addr_misaligned), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0BAD);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, $urandom);
        checkOutput("late_rvalid_inst", inst, 32'h0000_0013);

        for (int n = 0; n < 12; n++) randomFetch();

        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
